// File: rtl/mem_preload_writer_pkg.sv
// ----------------------------------------------------------------------------
// mem_preload_pkg : shared state encoding and memory-port codes for the loader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_preload_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/mem_preload_writer_if.sv
// ----------------------------------------------------------------------------
// mem_preload_if : control, byte stream, memory port and status bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mem_preload_if #(
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 10
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              verify_en;

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;

    logic              mem_enable;
    logic              mem_read_write;
    logic [1:0]        mem_size;
    logic              mem_sign_extend;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_in;
    logic [31:0]       mem_data_out;

    logic              busy;
    logic              done;
    logic              error;
    logic [LEN_W-1:0]  bytes_written;

    modport slave (
        input  start, base_addr, length, verify_en,
        input  in_valid, in_data,
        output in_ready,
        output mem_enable, mem_read_write, mem_size, mem_sign_extend,
        output mem_address, mem_data_in,
        input  mem_data_out,
        output busy, done, error, bytes_written
    );

    modport master (
        output start, base_addr, length, verify_en,
        output in_valid, in_data,
        input  in_ready,
        input  mem_enable, mem_read_write, mem_size, mem_sign_extend,
        input  mem_address, mem_data_in,
        output mem_data_out,
        input  busy, done, error, bytes_written
    );

endinterface

`default_nettype wire

// File: rtl/mem_preload_writer_pack.sv
// ----------------------------------------------------------------------------
// mem_preload_pack : 32-bit big-endian byte packer with fill counter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_preload_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [2:0]  fill_o
);

    logic [31:0] word_q;
    logic [2:0]  fill_q;

    // First byte ends up in [31:24] after four shifts; a lone byte sits in [7:0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= 32'h0;
            fill_q <= 3'd0;
        end else if (clear_i) begin
            word_q <= 32'h0;
            fill_q <= 3'd0;
        end else if (shift_i) begin
            word_q <= {word_q[23:0], byte_i};
            fill_q <= fill_q + 3'd1;
        end
    end

    assign word_o = word_q;
    assign fill_o = fill_q;

endmodule

`default_nettype wire

// File: rtl/mem_preload_writer.sv
// ----------------------------------------------------------------------------
// mem_preload_writer : streams bytes into memory as word/byte writes, with an
//                      optional read-back checksum pass. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_preload_writer
    import mem_preload_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 10
) (
    input  logic           clk,
    input  logic           reset,
    mem_preload_if.slave   bus
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  bw_q, bw_d;
    logic              verify_q, verify_d;
    logic [7:0]        sum_wr_q, sum_wr_d;
    logic [7:0]        sum_rd_q, sum_rd_d;
    logic              error_q, error_d;

    // Memory-port values are held between accesses
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              rw_q;

    logic              w_mem_en;
    logic              w_mem_rw;
    logic [1:0]        w_mem_size;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [31:0]       w_mem_wdata;
    logic              w_in_ready;
    logic              w_done;
    logic              w_accept;
    logic              w_word_path;
    logic [LEN_W-1:0]  w_step;
    logic              w_pack_clear;
    logic [31:0]       w_pack_word;
    logic [2:0]        w_pack_fill;
    logic              w_unused_rdata;

    assign w_accept       = (state_q == ST_COLLECT) && bus.in_valid;
    assign w_word_path    = (ptr_q[1:0] == 2'b00) && (rem_q >= LEN_W'(4));
    assign w_step         = w_word_path ? LEN_W'(4) : LEN_W'(1);
    assign w_unused_rdata = ^bus.mem_data_out[31:8];

    mem_preload_pack u_pack (
        .clk     (clk),
        .reset   (reset),
        .clear_i (w_pack_clear),
        .shift_i (w_accept),
        .byte_i  (bus.in_data),
        .word_o  (w_pack_word),
        .fill_o  (w_pack_fill)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            base_q   <= '0;
            rem_q    <= '0;
            len_q    <= '0;
            bw_q     <= '0;
            verify_q <= 1'b0;
            sum_wr_q <= 8'h0;
            sum_rd_q <= 8'h0;
            error_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            size_q   <= SIZE_BYTE;
            rw_q     <= RW_READ;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            base_q   <= base_d;
            rem_q    <= rem_d;
            len_q    <= len_d;
            bw_q     <= bw_d;
            verify_q <= verify_d;
            sum_wr_q <= sum_wr_d;
            sum_rd_q <= sum_rd_d;
            error_q  <= error_d;
            addr_q   <= w_mem_addr;
            wdata_q  <= w_mem_wdata;
            size_q   <= w_mem_size;
            rw_q     <= w_mem_rw;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        base_d       = base_q;
        rem_d        = rem_q;
        len_d        = len_q;
        bw_d         = bw_q;
        verify_d     = verify_q;
        sum_wr_d     = sum_wr_q;
        sum_rd_d     = sum_rd_q;
        error_d      = error_q;
        w_mem_en     = 1'b0;
        w_mem_rw     = rw_q;
        w_mem_size   = size_q;
        w_mem_addr   = addr_q;
        w_mem_wdata  = wdata_q;
        w_in_ready   = 1'b0;
        w_done       = 1'b0;
        w_pack_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    error_d      = 1'b0;
                    bw_d         = '0;
                    sum_wr_d     = 8'h0;
                    sum_rd_d     = 8'h0;
                    base_d       = bus.base_addr;
                    len_d        = bus.length;
                    verify_d     = bus.verify_en;
                    ptr_d        = bus.base_addr;
                    rem_d        = bus.length;
                    w_pack_clear = 1'b1;
                    if (bus.length > MAX_LEN) begin
                        error_d = 1'b1;
                    end else if (bus.length == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end

            ST_COLLECT: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    sum_wr_d = sum_wr_q + bus.in_data;
                    if (!w_word_path || (w_pack_fill == 3'd3)) begin
                        state_d = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                w_mem_en     = 1'b1;
                w_mem_rw     = RW_WRITE;
                w_mem_size   = w_word_path ? SIZE_WORD : SIZE_BYTE;
                w_mem_addr   = ptr_q;
                w_mem_wdata  = w_pack_word;
                w_pack_clear = 1'b1;
                ptr_d        = ptr_q + ADDR_W'(w_step);
                rem_d        = rem_q - w_step;
                bw_d         = bw_q + w_step;
                if (rem_q != w_step) begin
                    state_d = ST_COLLECT;
                end else if (verify_q) begin
                    state_d = ST_VERIFY;
                    ptr_d   = base_q;
                    rem_d   = len_q;
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_VERIFY: begin
                w_mem_en   = 1'b1;
                w_mem_rw   = RW_READ;
                w_mem_size = SIZE_BYTE;
                w_mem_addr = ptr_q;
                sum_rd_d   = sum_rd_q + bus.mem_data_out[7:0];
                ptr_d      = ptr_q + ADDR_W'(1);
                rem_d      = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (sum_rd_q == sum_wr_q) begin
                    state_d = ST_DONE;
                end else begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                w_done  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.mem_enable      = w_mem_en;
    assign bus.mem_read_write  = w_mem_rw;
    assign bus.mem_size        = w_mem_size;
    assign bus.mem_sign_extend = 1'b0;
    assign bus.mem_address     = w_mem_addr;
    assign bus.mem_data_in     = w_mem_wdata;
    assign bus.busy            = (state_q == ST_COLLECT) || (state_q == ST_WRITE) ||
                                 (state_q == ST_VERIFY)  || (state_q == ST_CHECK);
    assign bus.done            = w_done;
    assign bus.error           = error_q;
    assign bus.bytes_written   = bw_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_preload_writer.sv
// ----------------------------------------------------------------------------
// tb_mem_preload_writer : directed bench with a byte-array memory model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_preload_writer;
    import mem_preload_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_preload_if #(.ADDR_W(9), .LEN_W(10)) ifc ();

    mem_preload_writer #(.ADDR_W(9), .LEN_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    logic [7:0]  mem [512];
    logic        corrupt_armed;
    logic [43:0] log_q [$];
    logic [43:0] exp_q [$];
    logic [7:0]  tx_q  [$];
    int          total = 0;
    int          bad   = 0;
    logic        sd, se;

    assign ifc.mem_data_out = {24'h0, mem[ifc.mem_address]};

    // Memory model: word writes are big-endian; every access is logged
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h0;
        end else if (ifc.mem_enable) begin
            if (ifc.mem_read_write) begin
                if (ifc.mem_size == SIZE_WORD) begin
                    mem[ifc.mem_address]        <= ifc.mem_data_in[31:24];
                    mem[ifc.mem_address + 9'd1] <= ifc.mem_data_in[23:16];
                    mem[ifc.mem_address + 9'd2] <= ifc.mem_data_in[15:8];
                    mem[ifc.mem_address + 9'd3] <= ifc.mem_data_in[7:0];
                    log_q.push_back({1'b1, ifc.mem_size, ifc.mem_address, ifc.mem_data_in});
                end else begin
                    mem[ifc.mem_address] <= ifc.mem_data_in[7:0];
                    log_q.push_back({1'b1, ifc.mem_size, ifc.mem_address, 24'h0, ifc.mem_data_in[7:0]});
                end
                if (corrupt_armed) mem[9'd17] <= 8'hFF;
            end else begin
                log_q.push_back({1'b0, ifc.mem_size, ifc.mem_address, 32'h0});
            end
        end
    end

    function automatic logic [43:0] ent(input logic rw, input logic [1:0] sz,
                                        input logic [8:0] a, input logic [31:0] d);
        return {rw, sz, a, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [8:0] b, input logic [9:0] l, input logic v);
        @(negedge clk);
        ifc.start = 1'b1; ifc.base_addr = b; ifc.length = l; ifc.verify_en = v;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic feed();
        int   idx = 0;
        int   cyc = 0;
        logic acc;
        while (idx < tx_q.size() && cyc < 200) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = tx_q[idx];
            acc = ifc.in_ready;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        chk("feed_cnt", 64'(idx), 64'(tx_q.size()));
    endtask

    task automatic wait_end(output logic done_seen, output logic err_seen);
        done_seen = 1'b0;
        err_seen  = 1'b0;
        for (int i = 0; i < 60 && !done_seen && !err_seen; i++) begin
            if (ifc.done)       done_seen = 1'b1;
            else if (ifc.error) err_seen  = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic check_log(input string tag);
        logic [43:0] got;
        chk({tag, "_n"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < log_q.size()) ? log_q[i] : 44'h0;
            chk(tag, 64'(got), 64'(exp_q[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; corrupt_armed = 1'b0;
        ifc.start = 1'b0; ifc.base_addr = '0; ifc.length = '0; ifc.verify_en = 1'b0;
        ifc.in_valid = 1'b0; ifc.in_data = 8'h0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {ifc.in_ready, ifc.mem_enable, ifc.busy, ifc.done, ifc.error}, 0);
        chk("rst_bw", ifc.bytes_written, 0);
        chk("rst_bus", {ifc.mem_address, ifc.mem_data_in}, 0);
        reset = 1'b0;

        // aligned words
        log_q.delete(); exp_q.delete();
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_start(9'd0, 10'd8, 1'b0);
        chk("al_busy", ifc.busy, 1);
        feed();
        wait_end(sd, se);
        chk("al_done", {sd, se}, 2'b10);
        chk("al_bw", ifc.bytes_written, 8);
        @(negedge clk);
        chk("al_pulse", {ifc.done, ifc.busy}, 0);
        chk("al_bw_hold", ifc.bytes_written, 8);
        exp_q = '{ent(1, SIZE_WORD, 9'd0, 32'h11223344), ent(1, SIZE_WORD, 9'd4, 32'h55667788)};
        check_log("al_log");
        chk("al_mem", {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]},
            64'h1122334455667788);

        // unaligned head, word middle, byte tail
        log_q.delete();
        tx_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        do_start(9'd2, 10'd7, 1'b0);
        feed();
        wait_end(sd, se);
        chk("un_done", {sd, se}, 2'b10);
        chk("un_bw", ifc.bytes_written, 7);
        exp_q = '{ent(1, SIZE_BYTE, 9'd2, 32'hA0), ent(1, SIZE_BYTE, 9'd3, 32'hA1),
                  ent(1, SIZE_WORD, 9'd4, 32'hA2A3A4A5), ent(1, SIZE_BYTE, 9'd8, 32'hA6)};
        check_log("un_log");

        // wrap at top of memory
        log_q.delete();
        tx_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        do_start(9'd510, 10'd4, 1'b0);
        feed();
        wait_end(sd, se);
        chk("wr_done", {sd, se}, 2'b10);
        exp_q = '{ent(1, SIZE_BYTE, 9'd510, 32'hC0), ent(1, SIZE_BYTE, 9'd511, 32'hC1),
                  ent(1, SIZE_BYTE, 9'd0, 32'hC2), ent(1, SIZE_BYTE, 9'd1, 32'hC3)};
        check_log("wr_log");
        chk("wr_mem", {mem[510], mem[511], mem[0], mem[1]}, 32'hC0C1C2C3);

        // verify pass, clean
        log_q.delete();
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_start(9'd16, 10'd4, 1'b1);
        feed();
        wait_end(sd, se);
        chk("vf_done", {sd, se}, 2'b10);
        exp_q = '{ent(1, SIZE_WORD, 9'd16, 32'h01020304),
                  ent(0, SIZE_BYTE, 9'd16, 0), ent(0, SIZE_BYTE, 9'd17, 0),
                  ent(0, SIZE_BYTE, 9'd18, 0), ent(0, SIZE_BYTE, 9'd19, 0)};
        check_log("vf_log");

        // verify pass with corrupted byte 17
        log_q.delete();
        corrupt_armed = 1'b1;
        do_start(9'd16, 10'd4, 1'b1);
        feed();
        wait_end(sd, se);
        corrupt_armed = 1'b0;
        chk("cr_err", {sd, se}, 2'b01);
        chk("cr_busy", ifc.busy, 0);
        repeat (3) @(negedge clk);
        chk("cr_sticky", {ifc.error, ifc.done}, 2'b10);

        // zero length
        log_q.delete();
        @(negedge clk);
        ifc.start = 1'b1; ifc.base_addr = 9'd40; ifc.length = 10'd0; ifc.verify_en = 1'b0;
        @(negedge clk);
        ifc.start = 1'b0;
        chk("z_done", {ifc.done, ifc.busy, ifc.error}, 3'b100);
        @(negedge clk);
        chk("z_after", ifc.done, 0);
        chk("z_noacc", 64'(log_q.size()), 0);

        // over-length
        do_start(9'd0, 10'd513, 1'b0);
        chk("ol_err", {ifc.error, ifc.busy, ifc.done}, 3'b100);
        @(negedge clk);
        chk("ol_idle", {ifc.error, ifc.in_ready}, 2'b10);

        // start while busy is ignored
        log_q.delete();
        tx_q = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        do_start(9'd32, 10'd4, 1'b0);
        chk("sb_busy", ifc.busy, 1);
        ifc.start = 1'b1; ifc.base_addr = 9'd100; ifc.length = 10'd8; ifc.verify_en = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        feed();
        wait_end(sd, se);
        chk("sb_done", {sd, se}, 2'b10);
        chk("sb_bw", ifc.bytes_written, 4);
        exp_q = '{ent(1, SIZE_WORD, 9'd32, 32'h5A6B7C8D)};
        check_log("sb_log");

        // reset mid-transfer
        log_q.delete();
        tx_q = '{8'hE0, 8'hE1, 8'hE2};
        do_start(9'd0, 10'd8, 1'b0);
        feed();
        chk("mr_pre", {ifc.busy, ifc.mem_data_in}, {1'b1, 32'h5A6B7C8D});
        #2 reset = 1'b1;
        #1;
        chk("mr_ctl", {ifc.in_ready, ifc.mem_enable, ifc.busy, ifc.done, ifc.error}, 0);
        chk("mr_bus", {ifc.mem_address, ifc.mem_data_in, ifc.bytes_written}, 0);
        @(negedge clk);
        reset = 1'b0;
        log_q.delete();
        tx_q = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        do_start(9'd0, 10'd4, 1'b0);
        feed();
        wait_end(sd, se);
        chk("mr_done", {sd, se}, 2'b10);
        exp_q = '{ent(1, SIZE_WORD, 9'd0, 32'hD0D1D2D3)};
        check_log("mr_log");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_preload_writer.md
Name: mem_preload_writer

Overview:
- Synthesizable loader that drives the data memory (ram_512x8) port from a byte stream and writes a contiguous image starting at a programmed base address.
- It is the write-side counterpart of the memory dump/readout path.
- Packs big-endian (SPARC) bytes into word writes where alignment allows and uses byte writes elsewhere.
- Optional verify pass reads the region back and compares an 8-bit checksum.

Parameters:
- ADDR_W, 9, memory byte-address width (512 bytes)
- LEN_W, 10, transfer-length width (0..512 bytes)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches base_addr, length, verify_en
- base_addr  in  9  first byte address
- length  in  10  byte count, 0..512
- verify_en  in  1  run readback checksum pass after writes
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte this cycle
- mem_enable  out  1  memory access strobe (one cycle per access)
- mem_read_write  out  1  1 = write, 0 = read
- mem_size  out  2  00 byte, 01 halfword, 10 word
- mem_sign_extend  out  1  always 0
- mem_address  out  9  access address
- mem_data_in  out  32  write data; byte writes use bits [7:0]
- mem_data_out  in  32  combinational read data from memory
- busy  out  1  high from accepted start until done/error
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky until next accepted start; checksum mismatch or length>512
- bytes_written  out  10  count of bytes committed to memory

Behaviour:
- Reset (async): state IDLE; all outputs 0, including in_ready, mem_enable, mem_data_in, mem_address, and bytes_written. Internal pointer, remaining count, packing register, and checksums are cleared.
- IDLE:
  - start with length==0 -> done pulse the next cycle, busy stays 0.
  - start with length>512 -> error=1, stay IDLE.
  - Otherwise go to COLLECT with busy=1 and ptr=base_addr.
- start while busy: ignored.
- COLLECT:
  - in_ready=1. A byte is accepted on in_valid&&in_ready.
  - The byte is shifted into the packing register MSB-first. sum_wr += byte (mod 256).
  - Word path: ptr[1:0]==0 and remaining>=4 -> collect 4 bytes, then go to WRITE with size=10.
  - Byte path: otherwise (unaligned or remaining<4) -> go to WRITE after 1 byte with size=00.
- WRITE: exactly one cycle.
  - Drives mem_enable=1, mem_read_write=1, mem_address=ptr, mem_data_in=packed value.
  - in_ready=0.
  - ptr += 1 or 4, wrapping mod 512 (511 -> 0).
  - bytes_written and remaining are updated.
  - Next state: COLLECT if remaining>0; else VERIFY if verify_en; else DONE.
- VERIFY:
  - ptr reset to base_addr. Each cycle: mem_enable=1, mem_read_write=0, mem_size=00, mem_address=ptr.
  - mem_data_out[7:0] is sampled at that cycle's rising edge. sum_rd += byte; ptr wraps as above.
  - After length reads, go to CHECK.
- CHECK: sum_rd==sum_wr -> DONE, else set error and go to IDLE (busy=0, no done).
- DONE: done=1 for one cycle, busy=0, then IDLE. bytes_written holds until the next start.
- mem_enable is 0 in every state other than WRITE and VERIFY. mem_* values are don't-care when mem_enable=0 but held at their last value.
- Throughput: one stream byte per cycle while collecting; write overhead is one cycle per word or byte.
- reset mid-transfer: immediate abort to IDLE. A partial image remains in memory. No done or error is generated.

Decomposition:
- Shared package mem_preload_pkg holds:
  - state encoding localparams (IDLE, COLLECT, WRITE, VERIFY, CHECK, DONE)
  - size codes SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
  - RW_WRITE=1'b1, RW_READ=1'b0
- One natural sub-module: mem_preload_pack, the 32-bit big-endian byte packer with its fill counter.

Test Plan:
- Aligned word write: base=0, length=8, bytes 11..88. Expect two word writes: addr 0 data 32'h11223344, addr 4 data 32'h55667788. Then done; bytes_written=8; memory bytes 0..7 = 11..88.
- Unaligned and tail bytes: base=2, length=7, bytes A0..A6. Expect:
  - byte writes at addr 2 and 3
  - a word write at addr 4 = 32'hA2A3A4A5
  - a byte write at addr 8 = A6
- Address wrap: base=510, length=4. Expect byte writes at 510 and 511, then at 0 and 1; no word write.
- Verify pass: base=16, length=4, verify_en=1, bytes 01 02 03 04.
  - Expect 4 read cycles with size=00 at addresses 16..19, then done, error=0.
  - Repeat with a forced memory corruption of addr 17 to 0xFF before verify -> error=1, no done.
- Boundary lengths:
  - length=0 -> done one cycle after start, no mem_enable.
  - length=513 -> error=1, busy=0.
  - start pulse during busy -> ignored; the original transfer completes.
- Reset mid-operation: assert reset after 3 of 8 bytes -> outputs 0 asynchronously; the next start with base=0 and length=4 completes normally.
